// File: rtl/lb_fifo_csr_pkg.sv
// Shared definitions for the lb_fifo_csr CSR block: register byte addresses,
// CTRL/STATUS field positions and the read-response FSM state type.
package lb_fifo_csr_pkg;

   // Register byte addresses on the local bus
   localparam int unsigned ADDR_CTRL      = 'h00;
   localparam int unsigned ADDR_STATUS    = 'h04;
   localparam int unsigned ADDR_FIFO_DATA = 'h08;
   localparam int unsigned ADDR_PUSH_CNT  = 'h0C;

   // CTRL fields
   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_FLUSH_BIT   = 1;
   localparam int CTRL_SCRATCH_LSB = 8;
   localparam int CTRL_THRESH_LSB  = 16;

   // STATUS fields
   localparam int STATUS_EMPTY_BIT     = 0;
   localparam int STATUS_FULL_BIT      = 1;
   localparam int STATUS_UNDERFLOW_BIT = 2;
   localparam int STATUS_LEVEL_LSB     = 8;

   // Read-response FSM: one request in flight at a time
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_e;

endpackage

// File: rtl/lb_fifo_csr_if.sv
// Local-bus interface between the axil2lb bridge (master) and lb_fifo_csr (slave).
//
// Handshake rules:
//   write: a write takes effect on the rising edge where wen && wready; the
//          master holds waddr/wdata/wstrb/wen stable until that edge.
//   read : the master raises ren with raddr and holds both until it sees
//          rvalid; rvalid is a single-cycle strobe and rdata is only
//          meaningful while rvalid is high (it is 0 otherwise).
interface lb_fifo_csr_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              wready;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              wen;
   logic [STRB_W-1:0] wstrb;
   logic [ADDR_W-1:0] raddr;
   logic              ren;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (
      input  wready, rdata, rvalid,
      output waddr, wdata, wen, wstrb, raddr, ren
   );

   modport slave (
      output wready, rdata, rvalid,
      input  waddr, wdata, wen, wstrb, raddr, ren
   );
endinterface

// File: rtl/lb_fifo_csr_sync_fifo.sv
// lb_sync_fifo: single-clock FIFO with push/pop/flush, combinational head
// data. Pointers carry one extra MSB so full and empty are distinguished by
// comparing the wrap bit.
module lb_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         head,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   // Pointer update; flush wins over any pop in the same cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset because pointers gate visibility
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/lb_fifo_csr.sv
// lb_fifo_csr: local-bus CSR block fronting a synchronous data FIFO.
// Writes to FIFO_DATA push, reads pop; writes stall only when pushing into a
// full FIFO. Read data returns one cycle after the request is accepted.
// Optional feature: define LB_FIFO_CSR_IRQ_EN to add CTRL.THRESH and irq.
module lb_fifo_csr
   import lb_fifo_csr_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   lb_fifo_csr_if.slave bus,
`ifdef LB_FIFO_CSR_IRQ_EN
   output logic         irq,
`endif
   output rd_state_e    dbg_rd_state
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

   logic              en_q;
   logic [7:0]        scratch_q;
   logic              underflow_q;
   logic [DATA_W-1:0] push_cnt_q;
   logic [DATA_W-1:0] rdata_q;
`ifdef LB_FIFO_CSR_IRQ_EN
   logic [7:0]        thresh_q;
`endif

   logic              wr_fire, wr_ctrl, wr_status, wr_fifo;
   logic              push, pop, flush;
   logic              rd_accept, rd_fifo, rd_cnt, rd_underflow;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] rd_value;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;
   logic [LVL_W-1:0]  fifo_level;
   rd_state_e         state_q, state_d;

   // Only a push into a full FIFO is stalled; every other write completes now
   assign bus.wready = !(bus.wen && (bus.waddr == ADDR_W'(ADDR_FIFO_DATA)) && fifo_full);

   assign wr_fire   = bus.wen && bus.wready;
   assign wr_ctrl   = wr_fire && (bus.waddr == ADDR_W'(ADDR_CTRL));
   assign wr_status = wr_fire && (bus.waddr == ADDR_W'(ADDR_STATUS));
   assign wr_fifo   = wr_fire && (bus.waddr == ADDR_W'(ADDR_FIFO_DATA));

   // FLUSH is a pulse straight into the FIFO; it is never stored
   assign flush = wr_ctrl && bus.wstrb[0] && bus.wdata[CTRL_FLUSH_BIT];
   assign push  = wr_fifo && en_q;

   assign rd_accept    = (state_q == RD_IDLE) && bus.ren;
   assign rd_fifo      = rd_accept && (bus.raddr == ADDR_W'(ADDR_FIFO_DATA)) && en_q;
   assign pop          = rd_fifo && !fifo_empty;
   assign rd_underflow = rd_fifo && fifo_empty;
   assign rd_cnt       = rd_accept && (bus.raddr == ADDR_W'(ADDR_PUSH_CNT));

   // Pushed word keeps only the strobed bytes
   always_comb begin
      push_data = '0;
      for (int b = 0; b < STRB_W; b++) begin
         if (bus.wstrb[b]) push_data[b*8 +: 8] = bus.wdata[b*8 +: 8];
      end
   end

   lb_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (push_data),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // CTRL fields, byte-strobed
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q      <= 1'b0;
         scratch_q <= '0;
`ifdef LB_FIFO_CSR_IRQ_EN
         thresh_q  <= '0;
`endif
      end else if (wr_ctrl) begin
         if (bus.wstrb[0]) en_q <= bus.wdata[CTRL_EN_BIT];
         if (bus.wstrb[CTRL_SCRATCH_LSB/8]) scratch_q <= bus.wdata[CTRL_SCRATCH_LSB +: 8];
`ifdef LB_FIFO_CSR_IRQ_EN
         if (bus.wstrb[CTRL_THRESH_LSB/8]) thresh_q <= bus.wdata[CTRL_THRESH_LSB +: 8];
`endif
      end
   end

   // Sticky UNDERFLOW; a new underflow beats a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         underflow_q <= 1'b0;
      end else if (rd_underflow) begin
         underflow_q <= 1'b1;
      end else if (wr_status && bus.wstrb[0] && bus.wdata[STATUS_UNDERFLOW_BIT]) begin
         underflow_q <= 1'b0;
      end
   end

   // PUSH_CNT: saturating, cleared by a read; a push in the read cycle restarts at 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         push_cnt_q <= '0;
      end else if (rd_cnt) begin
         push_cnt_q <= push ? DATA_W'(1) : '0;
      end else if (push && (push_cnt_q != '1)) begin
         push_cnt_q <= push_cnt_q + DATA_W'(1);
      end
   end

`ifdef LB_FIFO_CSR_IRQ_EN
   // Registered level-threshold interrupt; THRESH=0 disables it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq <= 1'b0;
      else        irq <= en_q && (thresh_q != 8'd0) && (8'(fifo_level) >= thresh_q);
   end
`endif

   // Read mux evaluated at request-accept time; unmapped addresses return 0
   always_comb begin
      rd_value = '0;
      if (bus.raddr == ADDR_W'(ADDR_CTRL)) begin
         rd_value[CTRL_EN_BIT]           = en_q;
         rd_value[CTRL_SCRATCH_LSB +: 8] = scratch_q;
`ifdef LB_FIFO_CSR_IRQ_EN
         rd_value[CTRL_THRESH_LSB +: 8]  = thresh_q;
`endif
      end else if (bus.raddr == ADDR_W'(ADDR_STATUS)) begin
         rd_value[STATUS_EMPTY_BIT]      = fifo_empty;
         rd_value[STATUS_FULL_BIT]       = fifo_full;
         rd_value[STATUS_UNDERFLOW_BIT]  = underflow_q;
         rd_value[STATUS_LEVEL_LSB +: 8] = 8'(fifo_level);
      end else if (bus.raddr == ADDR_W'(ADDR_FIFO_DATA)) begin
         rd_value = pop ? fifo_head : '0;
      end else if (bus.raddr == ADDR_W'(ADDR_PUSH_CNT)) begin
         rd_value = push_cnt_q;
      end
   end

   // Read FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RD_IDLE;
      else        state_q <= state_d;
   end

   // Read FSM next state: accept in IDLE, respond for exactly one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         RD_IDLE: if (bus.ren) state_d = RD_RESP;
         RD_RESP: state_d = RD_IDLE;
         default: state_d = RD_IDLE;
      endcase
   end

   // Read FSM outputs
   always_comb begin
      bus.rvalid   = (state_q == RD_RESP);
      dbg_rd_state = state_q;
   end

   // Response data: captured on accept, zeroed as the response cycle ends
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (rd_accept) begin
         rdata_q <= rd_value;
      end else if (state_q == RD_RESP) begin
         rdata_q <= '0;
      end
   end

   assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_lb_fifo_csr.sv
// Directed bench for lb_fifo_csr. Build with +define+LB_FIFO_CSR_IRQ_EN to
// include the interrupt scenario.
module tb_lb_fifo_csr;
   import lb_fifo_csr_pkg::*;

   localparam logic [15:0] A_CTRL = 16'h00;
   localparam logic [15:0] A_STAT = 16'h04;
   localparam logic [15:0] A_FIFO = 16'h08;
   localparam logic [15:0] A_CNT  = 16'h0C;
   localparam logic [15:0] A_UNM  = 16'h10;

   logic      clk;
   logic      reset;
   rd_state_e dbg_rd_state;
`ifdef LB_FIFO_CSR_IRQ_EN
   logic      irq;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   lb_fifo_csr_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   lb_fifo_csr #(
      .ADDR_W     (16),
      .DATA_W     (32),
      .FIFO_DEPTH (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
`ifdef LB_FIFO_CSR_IRQ_EN
      .irq          (irq),
`endif
      .dbg_rd_state (dbg_rd_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      n = 0;
      bus.wen = 1'b1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
      #1;
      while (!bus.wready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_vec++;
      if (n >= 20) begin
         n_miss++;
         $display("FAIL write_timeout addr=%h: wready still 0 after %0d cycles, required 1", a, n);
      end
      @(posedge clk); #1;
      bus.wen = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic v);
      bus.ren = 1'b1; bus.raddr = a;
      @(posedge clk); #1;
      v = bus.rvalid;
      d = bus.rdata;
      bus.ren = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d; logic v;
      if (bus.rvalid !== 1'b0) begin n_miss++; $display("FAIL rst_rvalid: got %b required 0", bus.rvalid); end
      n_vec++;
      if (bus.rdata !== 32'h0) begin n_miss++; $display("FAIL rst_rdata: got %h required 0", bus.rdata); end
      n_vec++;
      if (bus.wready !== 1'b1) begin n_miss++; $display("FAIL rst_wready: got %b required 1", bus.wready); end
      n_vec++;
      if (dbg_rd_state !== RD_IDLE) begin n_miss++; $display("FAIL rst_state: got %0d required 0", dbg_rd_state); end
      n_vec++;
      reset = 1'b1;
      @(posedge clk); #1;
      bus_read(A_STAT, d, v);
      if (v !== 1'b1) begin n_miss++; $display("FAIL status_rvalid_latency: got %b required 1", v); end
      n_vec++;
      if (d !== 32'h0000_0001) begin n_miss++; $display("FAIL rst_status: got %h required 00000001", d); end
      n_vec++;
      if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
         n_miss++; $display("FAIL rvalid_one_cycle: got rvalid=%b rdata=%h required 0/0", bus.rvalid, bus.rdata);
      end
      n_vec++;
   endtask

   task automatic test_basic();
      logic [31:0] d; logic v;
      bus_write(A_CTRL, 32'h1, 4'hF);
      bus_write(A_FIFO, 32'hdeadbeef, 4'hF);
      bus_write(A_FIFO, 32'hc0debabe, 4'hF);
      bus_read(A_STAT, d, v);
      if (d !== 32'h0000_0200) begin n_miss++; $display("FAIL basic_level2: got %h required 00000200", d); end
      n_vec++;
      bus_read(A_FIFO, d, v);
      if (v !== 1'b1 || d !== 32'hdeadbeef) begin n_miss++; $display("FAIL basic_pop1: got %b/%h required 1/deadbeef", v, d); end
      n_vec++;
      bus_read(A_FIFO, d, v);
      if (v !== 1'b1 || d !== 32'hc0debabe) begin n_miss++; $display("FAIL basic_pop2: got %b/%h required 1/c0debabe", v, d); end
      n_vec++;
      bus_read(A_STAT, d, v);
      if (d !== 32'h0000_0001) begin n_miss++; $display("FAIL basic_empty: got %h required 00000001", d); end
      n_vec++;
   endtask

   task automatic test_full();
      logic [31:0] d; logic v;
      for (int i = 0; i < 8; i++) bus_write(A_FIFO, 32'h100 + i, 4'hF);
      bus_read(A_STAT, d, v);
      if (d !== 32'h0000_0802) begin n_miss++; $display("FAIL full_status: got %h required 00000802", d); end
      n_vec++;
      bus.wen = 1'b1; bus.waddr = A_FIFO; bus.wdata = 32'h0acce55; bus.wstrb = 4'hF;
      #1;
      if (bus.wready !== 1'b0) begin n_miss++; $display("FAIL full_wready_low: got %b required 0", bus.wready); end
      n_vec++;
      @(posedge clk); #1;
      if (bus.wready !== 1'b0) begin n_miss++; $display("FAIL full_wready_held: got %b required 0", bus.wready); end
      n_vec++;
      bus.ren = 1'b1; bus.raddr = A_FIFO;
      @(posedge clk); #1;
      bus.ren = 1'b0;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h100) begin
         n_miss++; $display("FAIL full_pop: got %b/%h required 1/00000100", bus.rvalid, bus.rdata);
      end
      n_vec++;
      if (bus.wready !== 1'b1) begin n_miss++; $display("FAIL full_wready_release: got %b required 1", bus.wready); end
      n_vec++;
      @(posedge clk); #1;
      bus.wen = 1'b0;
      bus_read(A_STAT, d, v);
      if (d !== 32'h0000_0802) begin n_miss++; $display("FAIL full_level8: got %h required 00000802", d); end
      n_vec++;
      for (int i = 1; i < 9; i++) begin
         logic [31:0] e;
         e = (i == 8) ? 32'h0acce55 : 32'h100 + i;
         bus_read(A_FIFO, d, v);
         if (d !== e) begin n_miss++; $display("FAIL full_drain%0d: got %h required %h", i, d, e); end
         n_vec++;
      end
      bus_read(A_CNT, d, v);
      if (d !== 32'd11) begin n_miss++; $display("FAIL push_cnt_11: got %h required 0000000b", d); end
      n_vec++;
   endtask

   task automatic test_underflow();
      logic [31:0] d; logic v;
      bus_read(A_FIFO, d, v);
      if (v !== 1'b1 || d !== 32'h0) begin n_miss++; $display("FAIL uf_pop_empty: got %b/%h required 1/0", v, d); end
      n_vec++;
      bus_read(A_STAT, d, v);
      if (d !== 32'h5) begin n_miss++; $display("FAIL uf_status: got %h required 00000005", d); end
      n_vec++;
      bus_write(A_STAT, 32'h4, 4'hF);
      bus_read(A_STAT, d, v);
      if (d !== 32'h1) begin n_miss++; $display("FAIL uf_clear: got %h required 00000001", d); end
      n_vec++;
   endtask

   task automatic test_strobe();
      logic [31:0] d; logic v;
      bus_write(A_FIFO, 32'hcafebabe, 4'b0110);
      bus_read(A_FIFO, d, v);
      if (d !== 32'h00feba00) begin n_miss++; $display("FAIL strb_push: got %h required 00feba00", d); end
      n_vec++;
      bus_read(A_CNT, d, v);
      if (d !== 32'd1) begin n_miss++; $display("FAIL cnt_one: got %h required 00000001", d); end
      n_vec++;
      bus_read(A_CNT, d, v);
      if (d !== 32'd0) begin n_miss++; $display("FAIL cnt_cleared: got %h required 0", d); end
      n_vec++;
      bus_write(A_CTRL, 32'h0000_5500, 4'b0010);
      bus_read(A_CTRL, d, v);
      if (d !== 32'h0000_5501) begin n_miss++; $display("FAIL ctrl_scratch_strb: got %h required 00005501", d); end
      n_vec++;
      bus_write(A_CTRL, 32'h00FF_AB03, 4'hF);
      bus_read(A_CTRL, d, v);
`ifdef LB_FIFO_CSR_IRQ_EN
      if (d !== 32'h00FF_AB01) begin n_miss++; $display("FAIL ctrl_readback: got %h required 00ffab01", d); end
`else
      if (d !== 32'h0000_AB01) begin n_miss++; $display("FAIL ctrl_readback: got %h required 0000ab01", d); end
`endif
      n_vec++;
      bus_read(A_UNM, d, v);
      if (v !== 1'b1 || d !== 32'h0) begin n_miss++; $display("FAIL unmapped_read: got %b/%h required 1/0", v, d); end
      n_vec++;
   endtask

   task automatic test_disabled();
      logic [31:0] d; logic v;
      bus_write(A_CTRL, 32'h0, 4'hF);
      bus.wen = 1'b1; bus.waddr = A_FIFO; bus.wdata = 32'h77; bus.wstrb = 4'hF;
      #1;
      if (bus.wready !== 1'b1) begin n_miss++; $display("FAIL dis_wready: got %b required 1", bus.wready); end
      n_vec++;
      @(posedge clk); #1;
      bus.wen = 1'b0;
      bus_read(A_STAT, d, v);
      if (d !== 32'h1) begin n_miss++; $display("FAIL dis_push_dropped: got %h required 00000001", d); end
      n_vec++;
      bus_read(A_CNT, d, v);
      if (d !== 32'h0) begin n_miss++; $display("FAIL dis_cnt: got %h required 0", d); end
      n_vec++;
      bus_read(A_FIFO, d, v);
      if (v !== 1'b1 || d !== 32'h0) begin n_miss++; $display("FAIL dis_pop: got %b/%h required 1/0", v, d); end
      n_vec++;
      bus_read(A_STAT, d, v);
      if (d !== 32'h1) begin n_miss++; $display("FAIL dis_no_uf: got %h required 00000001", d); end
      n_vec++;
      bus_write(A_CTRL, 32'h1, 4'hF);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic v;
      bus_write(A_FIFO, 32'h11, 4'hF);
      bus_write(A_FIFO, 32'h22, 4'hF);
      // flush and pop in the same cycle
      bus.wen = 1'b1; bus.waddr = A_CTRL; bus.wdata = 32'h3; bus.wstrb = 4'h1;
      bus.ren = 1'b1; bus.raddr = A_FIFO;
      @(posedge clk); #1;
      bus.wen = 1'b0; bus.ren = 1'b0;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h11) begin
         n_miss++; $display("FAIL flush_pop: got %b/%h required 1/00000011", bus.rvalid, bus.rdata);
      end
      n_vec++;
      @(posedge clk); #1;
      bus_read(A_STAT, d, v);
      if (d !== 32'h1) begin n_miss++; $display("FAIL flush_empty: got %h required 00000001", d); end
      n_vec++;
      // PUSH_CNT read with a push in the same cycle
      bus.wen = 1'b1; bus.waddr = A_FIFO; bus.wdata = 32'h33; bus.wstrb = 4'hF;
      bus.ren = 1'b1; bus.raddr = A_CNT;
      @(posedge clk); #1;
      bus.wen = 1'b0; bus.ren = 1'b0;
      if (bus.rdata !== 32'd2) begin n_miss++; $display("FAIL cnt_read_push_old: got %h required 00000002", bus.rdata); end
      n_vec++;
      @(posedge clk); #1;
      bus_read(A_CNT, d, v);
      if (d !== 32'd1) begin n_miss++; $display("FAIL cnt_read_push_new: got %h required 00000001", d); end
      n_vec++;
      // push and pop together keep LEVEL unchanged
      bus.wen = 1'b1; bus.waddr = A_FIFO; bus.wdata = 32'h44; bus.wstrb = 4'hF;
      bus.ren = 1'b1; bus.raddr = A_FIFO;
      @(posedge clk); #1;
      bus.wen = 1'b0; bus.ren = 1'b0;
      if (bus.rdata !== 32'h33) begin n_miss++; $display("FAIL pushpop_data: got %h required 00000033", bus.rdata); end
      n_vec++;
      @(posedge clk); #1;
      bus_read(A_STAT, d, v);
      if (d !== 32'h100) begin n_miss++; $display("FAIL pushpop_level: got %h required 00000100", d); end
      n_vec++;
      bus_read(A_FIFO, d, v);
      if (d !== 32'h44) begin n_miss++; $display("FAIL pushpop_tail: got %h required 00000044", d); end
      n_vec++;
   endtask

`ifdef LB_FIFO_CSR_IRQ_EN
   task automatic test_irq();
      logic [31:0] d; logic v;
      bus_write(A_CTRL, 32'h0003_0001, 4'hF);
      bus_write(A_FIFO, 32'h1, 4'hF);
      bus_write(A_FIFO, 32'h2, 4'hF);
      bus_write(A_FIFO, 32'h3, 4'hF);
      if (irq !== 1'b0) begin n_miss++; $display("FAIL irq_not_yet: got %b required 0", irq); end
      n_vec++;
      @(posedge clk); #1;
      if (irq !== 1'b1) begin n_miss++; $display("FAIL irq_set: got %b required 1", irq); end
      n_vec++;
      bus_write(A_CTRL, 32'h0003_0003, 4'hF);
      @(posedge clk); #1;
      if (irq !== 1'b0) begin n_miss++; $display("FAIL irq_flush: got %b required 0", irq); end
      n_vec++;
      bus_read(A_STAT, d, v);
      if (d !== 32'h1) begin n_miss++; $display("FAIL irq_level0: got %h required 00000001", d); end
      n_vec++;
   endtask
`endif

   // sequence and final report
   initial begin
      reset     = 1'b0;
      bus.wen   = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0;
      bus.ren   = 1'b0; bus.raddr = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_full();
      test_underflow();
      test_strobe();
      test_disabled();
      test_back_to_back();
`ifdef LB_FIFO_CSR_IRQ_EN
      test_irq();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
